// File: rtl/ram_write_queue.sv
// ram_write_queue: in-order staging queue for a 1R/2W RAM table.
// Takes up to two writes per cycle, drains the two oldest onto the RAM
// write ports, collapses same-address pairs, and bypasses pending data
// to the read path.
module ram_write_queue #(
  parameter int DEPTH  = 16,
  parameter int INDEX  = 4,
  parameter int WIDTH  = 8,
  parameter int QDEPTH = 8,
  parameter int QINDEX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq0_valid_i,
  input  logic [INDEX-1:0]  enq0_addr_i,
  input  logic [WIDTH-1:0]  enq0_data_i,
  input  logic              enq1_valid_i,
  input  logic [INDEX-1:0]  enq1_addr_i,
  input  logic [WIDTH-1:0]  enq1_data_i,
  output logic              enq_ready_o,
  input  logic              drain_en_i,
  output logic [INDEX-1:0]  addr0wr_o,
  output logic [WIDTH-1:0]  data0wr_o,
  output logic              we0_o,
  output logic [INDEX-1:0]  addr1wr_o,
  output logic [WIDTH-1:0]  data1wr_o,
  output logic              we1_o,
  input  logic [INDEX-1:0]  rd_addr_i,
  input  logic [WIDTH-1:0]  ram_data_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic [QINDEX:0]   count_o,
  output logic              empty_o
);

  // Elaboration-time sanity on the sizing parameters.
  if (DEPTH < 1 || DEPTH > (1 << INDEX)) begin : g_bad_depth
    $error("ram_write_queue: DEPTH must fit in INDEX address bits");
  end
  if (QDEPTH != (1 << QINDEX) || QDEPTH < 4) begin : g_bad_qdepth
    $error("ram_write_queue: QDEPTH must be 2**QINDEX and >= 4");
  end

  logic [INDEX-1:0]  r_addr [QDEPTH];
  logic [WIDTH-1:0]  r_data [QDEPTH];
  logic [QINDEX-1:0] r_head, r_tail;
  logic [QINDEX:0]   r_count;

  logic [QINDEX-1:0] w_head1, w_slot1;
  logic [1:0]        w_enq_n, w_deq_n;

  // Ready looks only at the registered count: room for a full pair.
  assign enq_ready_o = (r_count <= (QINDEX+1)'(QDEPTH - 2));
  assign w_enq_n     = enq_ready_o ? ({1'b0, enq0_valid_i} + {1'b0, enq1_valid_i}) : 2'd0;
  // enq1 lands right after enq0, or at tail when enq0 is idle.
  assign w_slot1     = r_tail + QINDEX'(enq0_valid_i);
  assign w_head1     = r_head + QINDEX'(1);
  assign count_o     = r_count;
  assign empty_o     = (r_count == '0);

  // Drain selection: up to two oldest entries, same-address pair keeps only the younger.
  always_comb begin
    we0_o     = 1'b0;
    we1_o     = 1'b0;
    addr0wr_o = r_addr[r_head];
    data0wr_o = r_data[r_head];
    addr1wr_o = r_addr[w_head1];
    data1wr_o = r_data[w_head1];
    w_deq_n   = 2'd0;
    if (drain_en_i && r_count != '0) begin
      if (r_count == (QINDEX+1)'(1)) begin
        we0_o   = 1'b1;
        w_deq_n = 2'd1;
      end else if (r_addr[r_head] == r_addr[w_head1]) begin
        we1_o   = 1'b1;
        w_deq_n = 2'd2;
      end else begin
        we0_o   = 1'b1;
        we1_o   = 1'b1;
        w_deq_n = 2'd2;
      end
    end
  end

  // Read bypass: scan oldest to youngest so the last hit (youngest) wins.
  always_comb begin
    rd_data_o = ram_data_i;
    for (int i = 0; i < QDEPTH; i++) begin
      if ((QINDEX+1)'(i) < r_count &&
          r_addr[r_head + QINDEX'(i)] == rd_addr_i)
        rd_data_o = r_data[r_head + QINDEX'(i)];
    end
  end

  // Entry storage: contents need no reset, only pointers/count qualify them.
  always_ff @(posedge clk) begin
    if (!reset && enq_ready_o) begin
      if (enq0_valid_i) begin
        r_addr[r_tail] <= enq0_addr_i;
        r_data[r_tail] <= enq0_data_i;
      end
      if (enq1_valid_i) begin
        r_addr[w_slot1] <= enq1_addr_i;
        r_data[w_slot1] <= enq1_data_i;
      end
    end
  end

  // Pointer and occupancy update; reset wins over same-cycle traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + QINDEX'(w_enq_n);
      r_head  <= r_head + QINDEX'(w_deq_n);
      r_count <= r_count + (QINDEX+1)'(w_enq_n) - (QINDEX+1)'(w_deq_n);
    end
  end

endmodule

// File: tb/tb_ram_write_queue.sv
// Directed bench for ram_write_queue with hand-computed expectations.
module tb_ram_write_queue;
  localparam int INDEX = 4, WIDTH = 8, QINDEX = 3;

  logic              clk, reset;
  logic              enq0_valid_i, enq1_valid_i;
  logic [INDEX-1:0]  enq0_addr_i, enq1_addr_i;
  logic [WIDTH-1:0]  enq0_data_i, enq1_data_i;
  logic              enq_ready_o, drain_en_i;
  logic [INDEX-1:0]  addr0wr_o, addr1wr_o;
  logic [WIDTH-1:0]  data0wr_o, data1wr_o;
  logic              we0_o, we1_o;
  logic [INDEX-1:0]  rd_addr_i;
  logic [WIDTH-1:0]  ram_data_i, rd_data_o;
  logic [QINDEX:0]   count_o;
  logic              empty_o;

  int n_cmp = 0;
  int n_err = 0;

  ram_write_queue #(.DEPTH(16), .INDEX(INDEX), .WIDTH(WIDTH), .QDEPTH(8), .QINDEX(QINDEX)) dut (
    .clk(clk), .reset(reset),
    .enq0_valid_i(enq0_valid_i), .enq0_addr_i(enq0_addr_i), .enq0_data_i(enq0_data_i),
    .enq1_valid_i(enq1_valid_i), .enq1_addr_i(enq1_addr_i), .enq1_data_i(enq1_data_i),
    .enq_ready_o(enq_ready_o), .drain_en_i(drain_en_i),
    .addr0wr_o(addr0wr_o), .data0wr_o(data0wr_o), .we0_o(we0_o),
    .addr1wr_o(addr1wr_o), .data1wr_o(data1wr_o), .we1_o(we1_o),
    .rd_addr_i(rd_addr_i), .ram_data_i(ram_data_i), .rd_data_o(rd_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic v0, input logic [3:0] a0, input logic [7:0] d0,
                     input logic v1, input logic [3:0] a1, input logic [7:0] d1);
    enq0_valid_i = v0; enq0_addr_i = a0; enq0_data_i = d0;
    enq1_valid_i = v1; enq1_addr_i = a1; enq1_data_i = d1;
  endtask

  task automatic noenq();
    enq(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic chk_ports(input string tag, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                           input logic w1, input logic [3:0] a1, input logic [7:0] d1);
    chk({tag, ".we0"}, 32'(we0_o), 32'(w0));
    chk({tag, ".we1"}, 32'(we1_o), 32'(w1));
    if (w0) begin
      chk({tag, ".addr0"}, 32'(addr0wr_o), 32'(a0));
      chk({tag, ".data0"}, 32'(data0wr_o), 32'(d0));
    end
    if (w1) begin
      chk({tag, ".addr1"}, 32'(addr1wr_o), 32'(a1));
      chk({tag, ".data1"}, 32'(data1wr_o), 32'(d1));
    end
  endtask

  initial begin
    reset = 1'b1; drain_en_i = 1'b1; rd_addr_i = 4'd0; ram_data_i = 8'h3C;
    noenq();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    // Reset state (drain enabled to show enables stay low when empty)
    chk("rst.count", 32'(count_o), 0);
    chk("rst.empty", 32'(empty_o), 1);
    chk("rst.ready", 32'(enq_ready_o), 1);
    chk("rst.we0", 32'(we0_o), 0);
    chk("rst.we1", 32'(we1_o), 0);
    chk("rst.rd", 32'(rd_data_o), 32'h3C);
    drain_en_i = 1'b0;

    // Basic pair, bypass, dual drain (head 0 -> 2)
    enq(1, 4'd3, 8'hAA, 1, 4'd5, 8'hBB);
    tick(); noenq(); rd_addr_i = 4'd5; #1;
    chk("t1.count", 32'(count_o), 2);
    chk("t1.empty", 32'(empty_o), 0);
    chk("t1.byp5", 32'(rd_data_o), 32'hBB);
    rd_addr_i = 4'd3; #1;
    chk("t1.byp3", 32'(rd_data_o), 32'hAA);
    rd_addr_i = 4'd6; #1;
    chk("t1.miss", 32'(rd_data_o), 32'h3C);
    drain_en_i = 1'b1; #1;
    chk_ports("t1.drain", 1, 4'd3, 8'hAA, 1, 4'd5, 8'hBB);
    tick(); drain_en_i = 1'b0; #1;
    chk("t1.count_after", 32'(count_o), 0);
    chk("t1.empty_after", 32'(empty_o), 1);

    // Fill to 7, drop when not ready, drain in FIFO order (head 2 -> 1)
    enq(1, 4'd1, 8'h10, 0, 4'd0, 8'h00); tick();
    enq(1, 4'd2, 8'h20, 1, 4'd3, 8'h30); tick();
    enq(1, 4'd4, 8'h40, 1, 4'd5, 8'h50); tick();
    enq(1, 4'd6, 8'h60, 1, 4'd8, 8'h80); tick();
    noenq(); #1;
    chk("t2.count7", 32'(count_o), 7);
    chk("t2.ready0", 32'(enq_ready_o), 0);
    enq(1, 4'd9, 8'h90, 1, 4'd10, 8'hA0); tick();
    noenq(); rd_addr_i = 4'd9; #1;
    chk("t2.drop_count", 32'(count_o), 7);
    chk("t2.drop_byp", 32'(rd_data_o), 32'h3C);
    rd_addr_i = 4'd8; #1;
    chk("t2.byp8", 32'(rd_data_o), 32'h80);
    drain_en_i = 1'b1; #1;
    chk_ports("t2.d0", 1, 4'd1, 8'h10, 1, 4'd2, 8'h20);
    tick();
    chk("t2.count5", 32'(count_o), 5);
    chk_ports("t2.d1", 1, 4'd3, 8'h30, 1, 4'd4, 8'h40);
    tick();
    chk_ports("t2.d2", 1, 4'd5, 8'h50, 1, 4'd6, 8'h60);
    tick();
    chk("t2.count1", 32'(count_o), 1);
    chk_ports("t2.d3", 1, 4'd8, 8'h80, 0, 4'd0, 8'h00);
    tick(); drain_en_i = 1'b0; #1;
    chk("t2.count0", 32'(count_o), 0);

    // enq1 alone while one entry pending (head 1 -> 3)
    enq(1, 4'd2, 8'h33, 0, 4'd0, 8'h00); tick();
    enq(0, 4'd0, 8'h00, 1, 4'd9, 8'h5C); tick();
    noenq(); #1;
    chk("t5.count", 32'(count_o), 2);
    drain_en_i = 1'b1; #1;
    chk_ports("t5.drain", 1, 4'd2, 8'h33, 1, 4'd9, 8'h5C);
    tick(); drain_en_i = 1'b0; #1;
    chk("t5.count0", 32'(count_o), 0);

    // Same-address collapse (head 3 -> 5)
    enq(1, 4'd7, 8'h11, 1, 4'd7, 8'h22); tick();
    noenq(); rd_addr_i = 4'd7; #1;
    chk("t3.count", 32'(count_o), 2);
    chk("t3.byp7", 32'(rd_data_o), 32'h22);
    drain_en_i = 1'b1; #1;
    chk_ports("t3.collapse", 0, 4'd0, 8'h00, 1, 4'd7, 8'h22);
    tick(); drain_en_i = 1'b0; #1;
    chk("t3.count0", 32'(count_o), 0);

    // Streaming enqueue+drain so pointers wrap; tail ends at slot 7
    drain_en_i = 1'b1;
    for (int k = 0; k < 21; k++) begin
      enq(1, 4'((2*k) % 16), 8'(8'h40 + 2*k), 1, 4'((2*k+1) % 16), 8'(8'h41 + 2*k));
      #1;
      if (k == 0)
        chk_ports("t4.first", 0, 4'd0, 8'h00, 0, 4'd0, 8'h00);
      else
        chk_ports($sformatf("t4.s%0d", k), 1, 4'((2*(k-1)) % 16), 8'(8'h40 + 2*(k-1)),
                  1, 4'((2*(k-1)+1) % 16), 8'(8'h41 + 2*(k-1)));
      tick();
    end
    drain_en_i = 1'b0;
    chk("t4.count_loop", 32'(count_o), 2);
    enq(1, 4'd4, 8'h01, 1, 4'd4, 8'h02); tick();
    noenq(); rd_addr_i = 4'd4; #1;
    chk("t4.count4", 32'(count_o), 4);
    chk("t4.wrap_byp", 32'(rd_data_o), 32'h02);
    drain_en_i = 1'b1; #1;
    chk_ports("t4.tail_pair", 1, 4'd8, 8'h68, 1, 4'd9, 8'h69);
    tick();
    chk_ports("t4.wrap_collapse", 0, 4'd0, 8'h00, 1, 4'd4, 8'h02);
    tick(); drain_en_i = 1'b0; #1;
    chk("t4.count0", 32'(count_o), 0);
    chk("t4.stale_byp", 32'(rd_data_o), 32'h3C);

    // Reset with six pending and a same-cycle enqueue+drain
    enq(1, 4'd1, 8'hC1, 1, 4'd2, 8'hC2); tick();
    enq(1, 4'd3, 8'hC3, 1, 4'd4, 8'hC4); tick();
    enq(1, 4'd5, 8'hC5, 1, 4'd6, 8'hC6); tick();
    noenq(); #1;
    chk("t6.count6", 32'(count_o), 6);
    reset = 1'b1; drain_en_i = 1'b1;
    enq(1, 4'd11, 8'hD1, 1, 4'd12, 8'hD2);
    tick();
    reset = 1'b0; noenq(); rd_addr_i = 4'd1; ram_data_i = 8'h5A; #1;
    chk("t6.count", 32'(count_o), 0);
    chk("t6.empty", 32'(empty_o), 1);
    chk("t6.we0", 32'(we0_o), 0);
    chk("t6.we1", 32'(we1_o), 0);
    chk("t6.ready", 32'(enq_ready_o), 1);
    chk("t6.rd", 32'(rd_data_o), 32'h5A);
    rd_addr_i = 4'd11; #1;
    chk("t6.rd_enq", 32'(rd_data_o), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_write_queue.md
Name: ram_write_queue

Overview:
- Write-side staging queue that sits directly upstream of a 1-read/2-write RAM table.
- Accepts up to two write requests per cycle and buffers them in order.
- Drains the two oldest requests per cycle onto the RAM's two write ports when the RAM is available.
- Provides a read-bypass path so a reader sees the youngest pending data for an address before it reaches the RAM.

Parameters:
DEPTH, 16, RAM entry count (pass-through; sizes nothing internally).
INDEX, 4, RAM address width.
WIDTH, 8, RAM data width.
QDEPTH, 8, queue entries; power of two, >= 4.
QINDEX, 3, log2(QDEPTH).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
enq0_valid_i  in  1  write request 0 (older of the pair).
enq0_addr_i  in  INDEX  request 0 address.
enq0_data_i  in  WIDTH  request 0 data.
enq1_valid_i  in  1  write request 1 (younger).
enq1_addr_i  in  INDEX  request 1 address.
enq1_data_i  in  WIDTH  request 1 data.
enq_ready_o  out  1  queue can accept two requests this cycle.
drain_en_i  in  1  RAM write ports available this cycle.
addr0wr_o  out  INDEX  RAM write port 0 address.
data0wr_o  out  WIDTH  RAM write port 0 data.
we0_o  out  1  RAM write port 0 enable.
addr1wr_o  out  INDEX  RAM write port 1 address.
data1wr_o  out  WIDTH  RAM write port 1 data.
we1_o  out  1  RAM write port 1 enable.
rd_addr_i  in  INDEX  read address, also driven to the RAM read port.
ram_data_i  in  WIDTH  RAM read data for rd_addr_i.
rd_data_o  out  WIDTH  bypassed read data.
count_o  out  QINDEX+1  occupied entries.
empty_o  out  1  count_o == 0.

Behaviour:
- Storage: circular buffer of {addr, data}, with head pointer, tail pointer and count registers. Pointers wrap modulo QDEPTH.
- Reset (synchronous, active-high):
  - head = tail = count = 0.
  - Storage contents are don't-care.
  - Resulting outputs: we0_o = we1_o = 0, enq_ready_o = 1, empty_o = 1, count_o = 0, rd_data_o = ram_data_i.
  - Reset overrides any enqueue or drain in the same cycle.
- enq_ready_o = (count <= QDEPTH-2).
  - Combinational from the registered count only; it does not look ahead to the current cycle's drain.
  - An enqueue presented while enq_ready_o = 0 is discarded and state is unchanged. Upstream must stall.
- Enqueue:
  - Valid requests are written at the clock edge in program order: enq0 at tail, then enq1.
  - If only enq1 is valid, it takes the slot at tail.
  - enq_n in {0,1,2}; tail advances by enq_n.
- Drain (combinational outputs from the head entries; the RAM captures them at the same edge that pops them):
  - drain_en_i = 0 or count = 0: we0_o = we1_o = 0.
  - count = 1: port 0 carries the head entry, we0_o = 1, we1_o = 0. deq_n = 1.
  - count >= 2, head and head+1 addresses differ: port 0 = head, port 1 = head+1, both enables high. deq_n = 2.
  - count >= 2, same address (collapse): we0_o = 0, we1_o = 1 with the head+1 (younger) entry. Both entries pop; deq_n = 2.
  - Address/data outputs are don't-care when the corresponding enable is low.
- Counter: count_next = count + enq_n - deq_n.
  - Simultaneous enqueue and drain are legal in every state, including full.
  - count never exceeds QDEPTH.
- Latency:
  - A request enqueued at edge N can be written to the RAM at edge N+1 at the earliest.
  - Order is FIFO; no reordering except the same-address collapse.
- Read bypass (combinational):
  - Search all valid queue entries (head .. head+count-1) for addr == rd_addr_i.
  - rd_data_o = data of the youngest match; if there is no match, rd_data_o = ram_data_i.
  - Requests enqueued in the current cycle are not visible to the bypass until the next cycle.
  - Entries draining in the current cycle remain visible until the edge.
- Queue-slot indexing uses QINDEX-bit wrap arithmetic.
- The youngest-match priority must hold across the wrap boundary.

Test Plan:
- Reset, then enq0 = (3, 0xAA), enq1 = (5, 0xBB), drain_en_i = 0 → count_o = 2, rd_addr_i = 5 gives rd_data_o = 0xBB. Next cycle drain_en_i = 1 → we0_o/addr0wr_o = 1/3, we1_o/addr1wr_o = 1/5, then count_o = 0, empty_o = 1.
- With drain disabled, enqueue pairs until count_o = 7 → enq_ready_o = 0. A further enqueue is dropped and count_o stays 7. Enable drain → the first four requests emerge in FIFO order over two cycles.
- Enqueue (7, 0x11) then (7, 0x22) in the same cycle, then drain → we0_o = 0, we1_o = 1, addr1wr_o = 7, data1wr_o = 0x22. count_o drops by 2.
- Run 20 cycles of two enqueues plus drain so the pointers wrap. Pending (4, 0x01) at slot 7 and (4, 0x02) at slot 0 → rd_addr_i = 4 gives 0x02. The RAM write sequence matches the enqueue order.
- Only enq1_valid_i = 1 with (9, 0x5C) while count = 1 → count_o = 2, and the entry drains on port 1 after the older entry on port 0.
- Assert reset while count = 6 with an enqueue in the same cycle → next cycle count_o = 0, we0_o = we1_o = 0, enq_ready_o = 1, rd_data_o = ram_data_i.
